// File: rtl/mire_writer_if.sv
// Wishbone bus bundle shared by the mire writer (master) and the SDRAM arbiter (slave).
interface wshb_if #(
  parameter int DATA_BYTES = 4
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/mire_writer.sv
// Wishbone master that endlessly writes a white-grid test pattern into the framebuffer in bursts.
// Optional feature macro MIRE_COLOR_EN: non-grid pixels become an x/y colour ramp instead of black.
module mire_writer #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int PAUSE = 1
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  wshb_if.master wshb_ifm,
  output logic   frame_done
);
  localparam int CW = 16;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int PW = (PAUSE > 1) ? $clog2(PAUSE) : 1;

  typedef enum logic {ST_WRITE, ST_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          cyc_q, cyc_d;
  logic          frame_done_q, frame_done_d;

  logic accept;
  logic last_x, last_y, last_b, last_p;

  // rty needs no logic: without ack/err the current pixel is simply held.
  logic unused_inputs;
  assign unused_inputs = ^{wshb_ifm.dat_sm, wshb_ifm.rty};

  assign accept = (state_q == ST_WRITE) && (wshb_ifm.ack || wshb_ifm.err);
  assign last_x = (x_q == CW'(HDISP - 1));
  assign last_y = (y_q == CW'(VDISP - 1));
  assign last_b = (bcnt_q == BW'(BURST - 1));
  assign last_p = (pcnt_q == PW'(PAUSE - 1));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    bcnt_d       = bcnt_q;
    pcnt_d       = pcnt_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    cyc_d        = cyc_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_WRITE: begin
        if (accept) begin
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d          = '0;
              adr_d        = 32'd0;
              frame_done_d = 1'b1;
            end else begin
              y_d   = y_q + CW'(1);
              adr_d = adr_q + 32'd4;
            end
          end else begin
            x_d   = x_q + CW'(1);
            adr_d = adr_q + 32'd4;
          end

          if (last_b) begin
            bcnt_d  = '0;
            state_d = ST_PAUSE;
            cyc_d   = 1'b0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end

          // Data is precomputed for the next pixel so it is ready when stb is presented.
          if (x_d[3:0] == 4'd0 || y_d[3:0] == 4'd0) begin
            dat_d = 32'h00FF_FFFF;
          end else begin
`ifdef MIRE_COLOR_EN
            dat_d = {8'h00, x_d[7:0], y_d[7:0], 8'h80};
`else
            dat_d = 32'h0000_0000;
`endif
          end
        end
      end

      ST_PAUSE: begin
        if (last_p) begin
          pcnt_d  = '0;
          state_d = ST_WRITE;
          cyc_d   = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end

      default: begin
        state_d = ST_PAUSE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_PAUSE;
      x_q          <= '0;
      y_q          <= '0;
      bcnt_q       <= '0;
      pcnt_q       <= '0;
      adr_q        <= 32'd0;
      dat_q        <= 32'h00FF_FFFF;
      cyc_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bcnt_q       <= bcnt_d;
      pcnt_q       <= pcnt_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      cyc_q        <= cyc_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wshb_ifm.cyc    = cyc_q;
  assign wshb_ifm.stb    = cyc_q;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = dat_q;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_mire_writer.sv
// Directed bench for mire_writer on a 32x4 frame with 8-write bursts and 2-cycle pauses.
module tb_mire_writer;
  localparam int HDISP = 32;
  localparam int VDISP = 4;
  localparam int BURST = 8;
  localparam int PAUSE = 2;
  localparam int NPIX  = HDISP * VDISP;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic frame_done;

  wshb_if #(.DATA_BYTES(4)) wshb ();

  mire_writer #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .PAUSE(PAUSE)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wshb_ifm   (wshb.master),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int pix = 0;
  int fd_count = 0;
  int gap = 0;
  int burst_acks = 0;
  int mode = 0;
  int ws = 0;
  bit prev_cyc = 1'b0;
  bit gap_valid = 1'b0;
  bit ten_valid = 1'b0;
  bit rty_armed = 1'b0, err_armed = 1'b0, both_armed = 1'b0;
  bit rty_seen = 1'b0, err_seen = 1'b0, both_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_dat(input int p);
    int x, y;
    x = p % HDISP;
    y = p / HDISP;
    if ((x % 16) == 0 || (y % 16) == 0) return 32'h00FF_FFFF;
`ifdef MIRE_COLOR_EN
    return {8'h00, 8'(x), 8'(y), 8'h80};
`else
    return 32'h0000_0000;
`endif
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // One bus cycle per iteration: check what the master presents, answer as the slave, then advance.
  task automatic run(input int ncyc);
    bit accepted;
    bit fd_exp;
    for (int i = 0; i < ncyc; i++) begin
      chk("stb_eq_cyc", {31'd0, wshb.stb}, {31'd0, wshb.cyc});
      if (wshb.cyc && !prev_cyc) begin
        if (gap_valid) chk("pause_len", gap, PAUSE);
        burst_acks = 0;
        ten_valid  = 1'b1;
      end
      if (!wshb.cyc && prev_cyc) begin
        if (ten_valid) begin
          chk("burst_len", burst_acks, BURST);
          gap_valid = 1'b1;
        end
        gap = 0;
      end
      if (!wshb.cyc) gap++;
      prev_cyc = wshb.cyc;

      wshb.ack = 1'b0;
      wshb.err = 1'b0;
      wshb.rty = 1'b0;
      accepted = 1'b0;
      if (wshb.stb) begin
        chk("adr", wshb.adr, 32'(pix * 4));
        chk("dat", wshb.dat_ms, exp_dat(pix));
        case (mode)
          1: begin
            if (ws == 3) begin
              wshb.ack = 1'b1;
              ws = 0;
            end else begin
              ws++;
            end
          end
          2: begin
            if (rty_armed && pix == 5) begin
              wshb.rty = 1'b1;
              rty_armed = 1'b0;
              rty_seen  = 1'b1;
            end else if (err_armed && pix == 6) begin
              wshb.err = 1'b1;
              err_armed = 1'b0;
              err_seen  = 1'b1;
            end else if (both_armed && pix == 9) begin
              wshb.ack = 1'b1;
              wshb.rty = 1'b1;
              both_armed = 1'b0;
              both_seen  = 1'b1;
            end else begin
              wshb.ack = 1'b1;
            end
          end
          default: wshb.ack = 1'b1;
        endcase
        if (wshb.ack || wshb.err) begin
          accepted = 1'b1;
          burst_acks++;
          $display("write pix=%0d adr=%h dat=%h %s", pix, wshb.adr, wshb.dat_ms,
                   wshb.err ? "err" : "ack");
          if (pix == 0)  chk("pix_0_0", wshb.dat_ms, 32'h00FF_FFFF);
          if (pix == 1)  chk("pix_1_0", wshb.dat_ms, 32'h00FF_FFFF);
`ifdef MIRE_COLOR_EN
          if (pix == 33) chk("pix_1_1", wshb.dat_ms, 32'h0001_0180);
`else
          if (pix == 33) chk("pix_1_1", wshb.dat_ms, 32'h0000_0000);
`endif
          if (pix == 80) chk("pix_16_2", wshb.dat_ms, 32'h00FF_FFFF);
          if (pix == NPIX - 1) chk("last_adr", wshb.adr, 32'h0000_01FC);
        end
      end
      fd_exp = accepted && (pix == NPIX - 1);
      step();
      chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
      if (frame_done) begin
        fd_count++;
        chk("frame_end_in_pause", {31'd0, wshb.cyc}, 32'd0);
      end
      if (accepted) pix = (pix + 1) % NPIX;
    end
  endtask

  initial begin
    int budget;
    wshb.ack = 1'b0;
    wshb.err = 1'b0;
    wshb.rty = 1'b0;
    wshb.dat_sm = '0;
    sys_rst = 1'b1;
    repeat (3) step();

    chk("rst_cyc", {31'd0, wshb.cyc}, 32'd0);
    chk("rst_stb", {31'd0, wshb.stb}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_adr", wshb.adr, 32'd0);
    chk("rst_dat", wshb.dat_ms, 32'h00FF_FFFF);
    chk("const_we", {31'd0, wshb.we}, 32'd1);
    chk("const_sel", {28'd0, wshb.sel}, 32'hF);
    chk("const_cti", {29'd0, wshb.cti}, 32'd0);
    chk("const_bte", {30'd0, wshb.bte}, 32'd0);

    // Release reset: stb must appear exactly PAUSE cycles later.
    sys_rst = 1'b0;
    step();
    chk("release_stb_c1", {31'd0, wshb.stb}, 32'd0);
    step();
    chk("release_stb_c2", {31'd0, wshb.stb}, 32'd1);

    mode = 0;
    run(165);
    chk("frame_done_count", fd_count, 1);

    mode = 1;
    ws = 0;
    run(100);

    mode = 2;
    rty_armed  = 1'b1;
    err_armed  = 1'b1;
    both_armed = 1'b1;
    run(200);
    chk("rty_seen", {31'd0, rty_seen}, 32'd1);
    chk("err_seen", {31'd0, err_seen}, 32'd1);
    chk("ack_rty_seen", {31'd0, both_seen}, 32'd1);

    // Walk forward until pixel (10,2) is on the bus, then pulse reset mid-burst.
    mode = 0;
    budget = 300;
    while (!(wshb.stb && pix == 2 * HDISP + 10) && budget > 0) begin
      run(1);
      budget--;
    end
    chk("reach_10_2", {31'd0, wshb.stb && pix == 2 * HDISP + 10}, 32'd1);
    wshb.ack = 1'b0;
    wshb.err = 1'b0;
    wshb.rty = 1'b0;
    sys_rst = 1'b1;
    step();
    chk("midrst_cyc", {31'd0, wshb.cyc}, 32'd0);
    chk("midrst_stb", {31'd0, wshb.stb}, 32'd0);
    chk("midrst_adr", wshb.adr, 32'd0);
    sys_rst = 1'b0;
    pix = 0;
    prev_cyc  = 1'b0;
    gap_valid = 1'b0;
    ten_valid = 1'b0;
    step();
    chk("restart_stb_c1", {31'd0, wshb.stb}, 32'd0);
    step();
    chk("restart_stb_c2", {31'd0, wshb.stb}, 32'd1);
    chk("restart_adr", wshb.adr, 32'd0);
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
